// File: rtl/wave_capture_pkg.sv
// Shared types for the oscilloscope capture block: FSM states and trigger modes.
package wave_capture_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_DONE    = 3'd3,
    ST_READ    = 3'd4
  } state_t;

  localparam logic [1:0] TRIG_IMM  = 2'd0;
  localparam logic [1:0] TRIG_RISE = 2'd1;
  localparam logic [1:0] TRIG_FALL = 2'd2;
  localparam logic [1:0] TRIG_BOTH = 2'd3;

endpackage

// File: rtl/wave_capture_ram.sv
// Capture buffer: simple dual-port RAM, one clock, registered read gated by re_i.
module capture_ram #(
  parameter int WIDTH = 8,
  parameter int AW    = 12
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [0:(2**AW)-1];

  // Write port and read port; rdata_o holds its value while re_i is low.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/wave_capture.sv
// Oscilloscope capture: decimate ADC samples, wait for a level trigger, store one
// buffer of samples, then stream them to the host over a ready/valid read port.
module wave_capture
  import wave_capture_pkg::*;
#(
  parameter int VERTICAL_RESOLUTION = 8,
  parameter int HORIZON_RESOLUTION  = 12,
  parameter int DECIM_WIDTH         = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [VERTICAL_RESOLUTION-1:0] sample_in,
  input  logic                           arm,
  input  logic [DECIM_WIDTH-1:0]         decim,
  input  logic [1:0]                     trig_mode,
  input  logic [VERTICAL_RESOLUTION-1:0] trig_level,
  output logic                           busy,
  output logic                           done,
  input  logic                           rd_enable,
  input  logic                           rd_ready,
  output logic                           rd_valid,
  output logic [31:0]                    rd_data
);

  localparam logic [HORIZON_RESOLUTION-1:0] ADDR_LAST = {HORIZON_RESOLUTION{1'b1}};
  localparam logic [HORIZON_RESOLUTION-1:0] ADDR_ZERO = {HORIZON_RESOLUTION{1'b0}};
  localparam logic [HORIZON_RESOLUTION-1:0] ADDR_ONE  = {{(HORIZON_RESOLUTION-1){1'b0}}, 1'b1};
  localparam logic [DECIM_WIDTH-1:0]        DCNT_ZERO = {DECIM_WIDTH{1'b0}};
  localparam logic [DECIM_WIDTH-1:0]        DCNT_ONE  = {{(DECIM_WIDTH-1){1'b0}}, 1'b1};

  state_t                           state_q;
  logic [DECIM_WIDTH-1:0]           decim_q;
  logic [DECIM_WIDTH-1:0]           dcnt_q;
  logic [DECIM_WIDTH-1:0]           dcnt_d;
  logic [1:0]                       mode_q;
  logic [VERTICAL_RESOLUTION-1:0]   level_q;
  logic [VERTICAL_RESOLUTION-1:0]   prev_q;
  logic                             prev_vld_q;
  logic [HORIZON_RESOLUTION-1:0]    waddr_q;
  logic [HORIZON_RESOLUTION-1:0]    raddr_q;
  logic [HORIZON_RESOLUTION-1:0]    beat_q;
  logic                             issue_done_q;
  logic                             ram_vld_q;
  logic                             busy_q;
  logic                             done_q;
  logic                             rd_valid_q;
  logic [VERTICAL_RESOLUTION-1:0]   rd_data_q;

  logic                             kept_s;
  logic                             rise_s;
  logic                             fall_s;
  logic                             trig_s;
  logic                             we_s;
  logic [HORIZON_RESOLUTION-1:0]    wr_addr_s;
  logic                             adv_s;
  logic                             re_s;
  logic                             beat_s;
  logic [VERTICAL_RESOLUTION-1:0]   ram_rdata_s;

  // Decimation, trigger detection and read-pipeline handshake terms.
  always_comb begin
    dcnt_d    = (dcnt_q == decim_q) ? DCNT_ZERO : (dcnt_q + DCNT_ONE);
    kept_s    = ((state_q == ST_ARMED) || (state_q == ST_CAPTURE)) && (dcnt_q == DCNT_ZERO);
    rise_s    = prev_vld_q && (prev_q < level_q) && (sample_in >= level_q);
    fall_s    = prev_vld_q && (prev_q >= level_q) && (sample_in < level_q);
    case (mode_q)
      TRIG_RISE: trig_s = rise_s;
      TRIG_FALL: trig_s = fall_s;
      TRIG_BOTH: trig_s = rise_s || fall_s;
      default:   trig_s = 1'b0;
    endcase
    we_s      = kept_s && !rst && !arm && ((state_q == ST_CAPTURE) || trig_s);
    wr_addr_s = (state_q == ST_CAPTURE) ? waddr_q : ADDR_ZERO;
    // The output stage moves only when empty or being consumed, so a stall freezes both stages.
    adv_s     = !rd_valid_q || rd_ready;
    re_s      = (state_q == ST_READ) && rd_enable && adv_s && !issue_done_q;
    beat_s    = (state_q == ST_READ) && rd_enable && rd_valid_q && rd_ready;
  end

  capture_ram #(
    .WIDTH (VERTICAL_RESOLUTION),
    .AW    (HORIZON_RESOLUTION)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (we_s),
    .waddr_i (wr_addr_s),
    .wdata_i (sample_in),
    .re_i    (re_s),
    .raddr_i (raddr_q),
    .rdata_o (ram_rdata_s)
  );

  // Control FSM with capture counters, read pipeline and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      decim_q      <= DCNT_ZERO;
      dcnt_q       <= DCNT_ZERO;
      mode_q       <= TRIG_IMM;
      level_q      <= {VERTICAL_RESOLUTION{1'b0}};
      prev_q       <= {VERTICAL_RESOLUTION{1'b0}};
      prev_vld_q   <= 1'b0;
      waddr_q      <= ADDR_ZERO;
      raddr_q      <= ADDR_ZERO;
      beat_q       <= ADDR_ZERO;
      issue_done_q <= 1'b0;
      ram_vld_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= {VERTICAL_RESOLUTION{1'b0}};
    end else if (arm && (state_q != ST_READ)) begin
      decim_q    <= decim;
      mode_q     <= trig_mode;
      level_q    <= trig_level;
      dcnt_q     <= DCNT_ZERO;
      waddr_q    <= ADDR_ZERO;
      prev_vld_q <= 1'b0;
      busy_q     <= 1'b1;
      done_q     <= 1'b0;
      state_q    <= (trig_mode == TRIG_IMM) ? ST_CAPTURE : ST_ARMED;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_q <= ST_IDLE;
        end
        ST_ARMED: begin
          dcnt_q <= dcnt_d;
          if (kept_s) begin
            if (trig_s) begin
              state_q <= ST_CAPTURE;
              waddr_q <= ADDR_ONE;
            end else begin
              prev_q     <= sample_in;
              prev_vld_q <= 1'b1;
            end
          end
        end
        ST_CAPTURE: begin
          dcnt_q <= dcnt_d;
          if (kept_s) begin
            if (waddr_q == ADDR_LAST) begin
              state_q <= ST_DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              waddr_q <= waddr_q + ADDR_ONE;
            end
          end
        end
        ST_DONE: begin
          if (rd_enable) begin
            state_q      <= ST_READ;
            done_q       <= 1'b0;
            raddr_q      <= ADDR_ZERO;
            beat_q       <= ADDR_ZERO;
            issue_done_q <= 1'b0;
            ram_vld_q    <= 1'b0;
          end
        end
        ST_READ: begin
          if (!rd_enable) begin
            state_q    <= ST_DONE;
            done_q     <= 1'b1;
            ram_vld_q  <= 1'b0;
            rd_valid_q <= 1'b0;
          end else begin
            if (adv_s) begin
              ram_vld_q  <= re_s;
              rd_valid_q <= ram_vld_q;
              if (ram_vld_q) begin
                rd_data_q <= ram_rdata_s;
              end
            end
            if (re_s) begin
              if (raddr_q == ADDR_LAST) begin
                issue_done_q <= 1'b1;
              end else begin
                raddr_q <= raddr_q + ADDR_ONE;
              end
            end
            if (beat_s) begin
              if (beat_q == ADDR_LAST) begin
                state_q    <= ST_DONE;
                done_q     <= 1'b1;
                rd_valid_q <= 1'b0;
              end else begin
                beat_q <= beat_q + ADDR_ONE;
              end
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = {{(32-VERTICAL_RESOLUTION){1'b0}}, rd_data_q};

endmodule

// File: tb/tb_wave_capture.sv
// Randomized bench for wave_capture: records every driven sample and derives the
// expected buffer from the trigger/decimation rules applied to that history.
module tb_wave_capture;
  import wave_capture_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  sample_in = 8'd0;
  logic        arm = 1'b0;
  logic [15:0] decim = 16'd0;
  logic [1:0]  trig_mode = 2'd0;
  logic [7:0]  trig_level = 8'd0;
  logic        busy, done, rd_valid;
  logic        rd_enable = 1'b0;
  logic        rd_ready = 1'b0;
  logic [31:0] rd_data;

  wave_capture dut (
    .clk(clk), .rst(rst), .sample_in(sample_in), .arm(arm), .decim(decim),
    .trig_mode(trig_mode), .trig_level(trig_level), .busy(busy), .done(done),
    .rd_enable(rd_enable), .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         wave_sel = 0;
  logic [7:0] const_val = 8'd0;
  logic [7:0] hist [int];
  logic [7:0] expd [0:4095];
  logic [7:0] rq [$];
  logic [7:0] q1 [$];
  int         cap_arm, cap_step, exp_start;
  logic [1:0] cap_mode;
  logic [7:0] cap_level;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] gen(input int n);
    case (wave_sel)
      0: return n[7:0];
      1: return 8'(int'(128.0 + 120.0 * $sin(6.2831853 * real'(n) / 97.0)));
      2: return const_val;
      default: return 8'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic tick();
    hist[cyc + 1] = sample_in;
    @(posedge clk);
    cyc++;
    #1;
    sample_in = gen(cyc + 1);
  endtask

  task automatic set_wave(input int sel, input logic [7:0] cv);
    wave_sel  = sel;
    const_val = cv;
    sample_in = gen(cyc + 1);
  endtask

  task automatic do_arm(input logic [1:0] m, input int d, input logic [7:0] lv);
    trig_mode  = m;
    decim      = 16'(d);
    trig_level = lv;
    arm        = 1'b1;
    cap_arm    = cyc + 1;
    cap_mode   = m;
    cap_step   = d + 1;
    cap_level  = lv;
    tick();
    arm = 1'b0;
    check_eq("busy_after_arm", busy, 1);
  endtask

  // Wait for done, then build the expected buffer from the recorded input history.
  task automatic finish_capture(input string tag);
    int bound;
    int e0;
    bit found;
    logic [7:0] pv, cv;
    bit hit;
    bound = 4096 * cap_step + 6000;
    for (int i = 0; i < bound; i++) begin
      if (done) break;
      tick();
    end
    check_eq({tag, "_done_seen"}, done, 1);
    e0 = cap_arm + 1;
    found = 1'b0;
    exp_start = e0;
    if (cap_mode == TRIG_IMM) begin
      found = 1'b1;
    end else begin
      for (int k = 1; (e0 + k * cap_step <= cyc) && !found; k++) begin
        pv = hist[e0 + (k - 1) * cap_step];
        cv = hist[e0 + k * cap_step];
        case (cap_mode)
          TRIG_RISE: hit = (pv < cap_level) && (cv >= cap_level);
          TRIG_FALL: hit = (pv >= cap_level) && (cv < cap_level);
          default:   hit = ((pv < cap_level) && (cv >= cap_level)) || ((pv >= cap_level) && (cv < cap_level));
        endcase
        if (hit) begin
          found = 1'b1;
          exp_start = e0 + k * cap_step;
        end
      end
    end
    check_eq({tag, "_trigger_found"}, found, 1);
    for (int i = 0; i < 4096; i++) expd[i] = hist[exp_start + i * cap_step];
    check_eq({tag, "_done_edge"}, cyc, exp_start + 4095 * cap_step);
  endtask

  // Host read of n_want beats; optionally random rd_ready and an arm pulse mid-read.
  task automatic do_read(input string tag, input int n_want, input bit rand_rdy, input int arm_at);
    int e, first, stall_err, gap_err, busy_err, hi_err, errs;
    bit prev_stall, fin;
    logic [7:0] prev_data;
    first = -1; stall_err = 0; gap_err = 0; busy_err = 0; hi_err = 0; errs = 0;
    prev_stall = 1'b0; fin = 1'b0; prev_data = 8'd0;
    rq.delete();
    rd_enable = 1'b1;
    rd_ready  = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    e = cyc + 1;
    for (int it = 0; it < 40000 && !fin; it++) begin
      tick();
      arm = 1'b0;
      if (prev_stall && (!rd_valid || rd_data[7:0] != prev_data)) stall_err++;
      if (rd_valid && first < 0) first = cyc;
      if (!rand_rdy && first >= 0 && !rd_valid) gap_err++;
      if (busy) busy_err++;
      if (rd_valid && rd_data[31:8] != 24'd0) hi_err++;
      rd_ready   = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      prev_stall = rd_valid && !rd_ready;
      prev_data  = rd_data[7:0];
      if (rd_valid && rd_ready) begin
        rq.push_back(rd_data[7:0]);
        if (rq.size() == arm_at) arm = 1'b1;
        if (rq.size() == n_want) fin = 1'b1;
      end
    end
    tick();
    arm = 1'b0;
    check_eq({tag, "_beats"}, rq.size(), n_want);
    check_eq({tag, "_first_valid_latency"}, first - e, 2);
    if (n_want < 4096) begin
      rd_enable = 1'b0;
      rd_ready  = 1'b0;
      tick();
      check_eq({tag, "_abort_valid_low"}, rd_valid, 0);
      check_eq({tag, "_abort_done"}, done, 1);
    end else begin
      check_eq({tag, "_valid_low_after_last"}, rd_valid, 0);
      check_eq({tag, "_done_after_last"}, done, 1);
      rd_enable = 1'b0;
      rd_ready  = 1'b0;
    end
    if (rand_rdy) check_eq({tag, "_stall_hold_errs"}, stall_err, 0);
    else          check_eq({tag, "_bubble_count"}, gap_err, 0);
    check_eq({tag, "_busy_in_read"}, busy_err, 0);
    check_eq({tag, "_upper_bits"}, hi_err, 0);
    foreach (rq[i]) if (rq[i] != expd[i]) errs++;
    check_eq({tag, "_data_errs"}, errs, 0);
  endtask

  initial begin
    int viol, errs;
    set_wave(0, 8'd0);
    // reset state
    for (int i = 0; i < 3; i++) tick();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_rd_valid", rd_valid, 0);
    check_eq("rst_rd_data", rd_data, 0);
    rst = 1'b0;
    tick();

    // immediate capture of a ramp, full-speed readout
    do_arm(TRIG_IMM, 0, 8'd0);
    finish_capture("ramp");
    do_read("ramp_rd", 4096, 1'b0, -1);

    // rising trigger on a sine, decimate by 4, random backpressure, then re-read
    set_wave(1, 8'd0);
    do_arm(TRIG_RISE, 3, 8'h80);
    finish_capture("rise");
    do_read("rise_rd1", 4096, 1'b1, -1);
    check_eq("rise_beat0_ge_level", rq[0] >= 8'h80, 1);
    q1 = rq;
    do_read("rise_rd2", 4096, 1'b0, -1);
    errs = 0;
    foreach (rq[i]) if (rq[i] != q1[i]) errs++;
    check_eq("rise_reread_diff", errs, 0);

    // falling trigger held off by a flat input, then released by a step
    set_wave(2, 8'h10);
    do_arm(TRIG_FALL, $urandom_range(0, 1), 8'h80);
    viol = 0;
    for (int i = 0; i < 2000; i++) begin
      tick();
      if (!busy || done) viol++;
    end
    check_eq("fall_hold_armed", viol, 0);
    set_wave(2, 8'hF0);
    for (int i = 0; i < 40; i++) tick();
    set_wave(2, 8'h10);
    finish_capture("fall");
    do_read("abort_rd", 100, 1'b0, -1);
    do_read("after_abort_rd", 4096, 1'b0, -1);

    // random noise with a random trigger mode and level
    set_wave(3, 8'd0);
    do_arm(2'($urandom_range(1, 3)), $urandom_range(0, 1), 8'($urandom_range(32, 224)));
    finish_capture("noise");
    do_read("noise_rd", 4096, 1'b1, -1);

    // reset mid-capture (with a simultaneous arm), then a clean capture
    set_wave(0, 8'd0);
    do_arm(TRIG_IMM, 0, 8'd0);
    for (int i = 0; i < 500; i++) tick();
    rst = 1'b1;
    arm = 1'b1;
    tick();
    arm = 1'b0;
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_done", done, 0);
    check_eq("midrst_rd_valid", rd_valid, 0);
    check_eq("midrst_rd_data", rd_data, 0);
    rst = 1'b0;
    tick();
    check_eq("midrst_idle_busy", busy, 0);
    do_arm(TRIG_IMM, 0, 8'd0);
    finish_capture("post_rst");
    do_read("post_rst_rd", 4096, 1'b0, 50);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/wave_capture.md
# wave_capture

Oscilloscope-style capture block: the reader-side counterpart of the DDS waveform store. It samples an ADC data bus and decimates it. It waits for a level-crossing trigger, stores 2**HORIZON_RESOLUTION samples in block RAM, then streams them to the host over a 32-bit rd_enable/rd_valid/rd_ready port. That port mirrors the DDS wr_enable/wr_valid/wr_data load port. It sits between the ADC front end and the host bridge, in the same clock domain as the DDS.

## Interface
- VERTICAL_RESOLUTION, 8, sample width in bits
- HORIZON_RESOLUTION, 12, log2 of capture depth (4096 samples)
- DECIM_WIDTH, 16, width of decimation ratio
- clk  input  1  system clock, 50 MHz
- rst  input  1  reset; synchronous, active-high
- sample_in  input  VERTICAL_RESOLUTION  ADC sample, new value every clk
- arm  input  1  one-cycle pulse, starts a capture
- decim  input  DECIM_WIDTH  keep one sample every decim+1 clocks; latched on arm
- trig_mode  input  2  0 immediate, 1 rising, 2 falling, 3 either; latched on arm
- trig_level  input  VERTICAL_RESOLUTION  trigger threshold, unsigned; latched on arm
- busy  output  1  high in ARMED or CAPTURE
- done  output  1  high in DONE, i.e. a complete capture is held
- rd_enable  input  1  host read request; level, held for the whole transfer
- rd_ready  input  1  host accepts rd_data this cycle
- rd_valid  output  1  rd_data valid
- rd_data  output  32  sample, zero-extended from VERTICAL_RESOLUTION

## Operation
- States: IDLE, ARMED, CAPTURE, DONE, READ.
- Reset: state IDLE. busy, done, rd_valid and rd_data are all 0. RAM contents are not cleared.
- Decimation:
  - A modulo-(decim+1) counter restarts at 0 on arm.
  - A "kept" sample is the one where counter==0.
  - decim=0 keeps every sample.
- Trigger, evaluated on kept samples only. prev is the previous kept sample.
  - rising: prev < level AND cur >= level.
  - falling: prev >= level AND cur < level.
  - either: rising OR falling.
  - The first kept sample after arm has no prev and never triggers.
- IDLE or DONE, on arm:
  - trig_mode=0 goes to CAPTURE; the first kept sample goes to address 0.
  - Any other mode goes to ARMED.
- ARMED, on trigger: the triggering sample is written at address 0 and the state goes to CAPTURE.
- CAPTURE: each kept sample is written at the next address. After address 2**H-1 is written, go to DONE.
- arm in ARMED or CAPTURE restarts the capture: decimation counter, write address and prev-valid are all cleared.
- arm in READ is ignored.
- DONE with rd_enable=1 goes to READ. Read address starts at 0.
- READ:
  - Samples are presented in address order 0..2**H-1.
  - A beat transfers when rd_valid AND rd_ready.
  - After the final beat transfers, go to DONE. The data is kept and can be read again.
- rd_enable falling in READ aborts the read:
  - rd_valid goes to 0 on the next cycle and the state returns to DONE.
  - The next read starts at address 0.
- Write and read addresses are HORIZON_RESOLUTION bits. The write address wraps to 0 only via restart, never mid-capture.

## Timing
- arm sampled at edge t: busy=1 from t+1.
- Immediate mode with decim=0: the sample at edge t+1 is written to address 0. The last write is at t+2**H, and done=1 from t+2**H+1.
- Trigger seen at edge t: the state is CAPTURE from t+1, and the trigger sample is written at edge t.
- READ entered at edge t: first rd_valid=1 at t+2 (RAM read latency of 1 plus output register).
- With rd_ready held high, one beat per clock with no bubbles.
- rd_ready low stalls: rd_valid and rd_data hold unchanged. The RAM read enable and the address do not advance.
- rd_valid deasserts the cycle after the final beat.
- rst takes precedence over every other input in the same cycle.

## Structure
- Package wave_capture_pkg holds:
  - the state_t enum (IDLE, ARMED, CAPTURE, DONE, READ);
  - the trig_mode localparams TRIG_IMM, TRIG_RISE, TRIG_FALL, TRIG_BOTH.
- Sub-module capture_ram: simple dual-port, one clock, synchronous read with rd_en, width VERTICAL_RESOLUTION, depth 2**HORIZON_RESOLUTION.
- The top level contains:
  - FSM;
  - decimation counter;
  - prev register and trigger comparator;
  - write address counter;
  - read address counter and output pipeline.

## Test plan
- Immediate, decim=0, sample_in = ramp 0..255 repeating. Arm, then read with rd_ready=1. Required:
  - done after 4096 writes;
  - 4096 beats, back-to-back;
  - beat k = ramp value at arm+1+k.
- Rising trigger at level 0x80, decim=3, sine input. Required:
  - beat 0 >= 0x80 and the previous kept sample < 0x80;
  - consecutive beats are 4 input clocks apart.
- Falling trigger with input held at 0x10. Required: stays ARMED, busy=1, done=0 indefinitely. Then step the input across the level and confirm a capture completes.
- Readout with rd_ready toggled pseudo-randomly. Required:
  - rd_data stable while stalled;
  - no lost or duplicated samples;
  - the read returns to DONE, and a second read returns identical data.
- Abort: drop rd_enable after 100 beats. Required: rd_valid=0 next cycle. A new read starts at address 0.
- rst mid-CAPTURE, then arm again. Required:
  - all outputs 0 the cycle after rst;
  - the new capture completes normally;
  - arm in READ has no effect.
